// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell and a borrow flop.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, res, res_n;
  logic [CW-1:0] cnt;
  logic br, d, nbr, last;
  always_comb begin
    d     = a_sr[0] ^ b_sr[0] ^ br;
    nbr   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    last  = cnt == CW'(WIDTH - 1);
    res_n = WIDTH'({d, res} >> 1);
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          b_sr  <= b;
          br    <= bin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= res_n;
          br   <= nbr;
          cnt  <= last ? '0 : cnt + CW'(1);
          if (last) begin
            diff  <= res_n;
            bout  <= nbr;
`ifdef SERIAL_SUB_OVF_EN
            // br is the borrow into the MSB on the last cycle
            ovf   <= br ^ nbr;
`endif
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [W-1:0] a, b, diff;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`endif
  int checks = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic bin;
    logic [W-1:0] d;
    logic bo, ov;
  } vec_t;

  // Presents operands at a falling edge, waits (bounded) for acceptance, returns one negedge after the accept edge.
  task automatic do_accept(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
    int n = 0;
    @(negedge clk);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, diff, bout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset in_ready=%b out_valid=%b diff=%h bout=%b required 1 0 00 0",
               in_ready, out_valid, diff, bout);
    end
  endtask

  task automatic test_vectors;
    vec_t v[6];
    logic early;
    v[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    v[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    v[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    v[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    v[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    v[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_accept(v[i].a, v[i].b, v[i].bin);
      early = 1'b0;
      for (int k = 1; k < W; k++) begin
        @(negedge clk);
        if (out_valid !== 1'b0 || in_ready !== 1'b0) early = 1'b1;
      end
      checks++;
      if (early) begin
        fails++;
        $display("FAIL vec%0d_run out_valid or in_ready high before %0d cycles", i, W);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, diff, bout} !== {1'b1, v[i].d, v[i].bo}) begin
        fails++;
        $display("FAIL vec%0d_result out_valid=%b diff=%h bout=%b required 1 %h %b",
                 i, out_valid, diff, bout, v[i].d, v[i].bo);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== v[i].ov) begin
        fails++;
        $display("FAIL vec%0d_ovf ovf=%b required %b", i, ovf, v[i].ov);
      end
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        fails++;
        $display("FAIL vec%0d_release in_ready=%b out_valid=%b required 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    do_accept(8'h5A, 8'h23, 1'b0);
    repeat (W) @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, diff, bout} !== {1'b1, 1'b0, 8'h37, 1'b0}) begin
        fails++;
        $display("FAIL hold%0d out_valid=%b in_ready=%b diff=%h bout=%b required 1 0 37 0",
                 k, out_valid, in_ready, diff, bout);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, diff} !== {1'b1, 1'b0, 8'h37}) begin
      fails++;
      $display("FAIL hold_release in_ready=%b out_valid=%b diff=%h required 1 0 37",
               in_ready, out_valid, diff);
    end
  endtask

  task automatic test_reset_mid_run;
    do_accept(8'h5A, 8'h23, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, diff, bout} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL midrun_reset out_valid=%b in_ready=%b diff=%h bout=%b required 0 1 00 0",
               out_valid, in_ready, diff, bout);
    end
    do_accept(8'h05, 8'h07, 1'b0);
    repeat (W) @(negedge clk);
    checks++;
    if ({out_valid, diff, bout} !== {1'b1, 8'hFE, 1'b1}) begin
      fails++;
      $display("FAIL after_reset out_valid=%b diff=%h bout=%b required 1 FE 1", out_valid, diff, bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_ovf ovf=%b required 0", ovf);
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
